// File: rtl/readbuf_stream_arbiter.sv
// Frame-level round-robin arbiter sharing one AXI-Stream byte port among NREQ
// readbuf channels, with a source-starvation watchdog that releases a stalled grant.
module readbuf_stream_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int TOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          s_tvalid,
  input  logic [NREQ-1:0]          s_tlast,
  input  logic [NREQ*DW-1:0]       s_tdata,
  output logic [NREQ-1:0]          s_tready,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  output logic [DW-1:0]            m_tdata,
  input  logic                     m_tready,
  output logic [NREQ-1:0]          grant,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     timeout_err
);

  localparam int IW = $clog2(NREQ);
  localparam int WW = $clog2(TOUT + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt, grant_id_nxt, pick;
  logic            pick_vld;
  logic [NREQ-1:0] grant_nxt;
  logic [WW-1:0]   wd_cnt, wd_nxt;
  logic            frame_done_nxt, timeout_err_nxt;
  logic            cur_valid, cur_last, hs;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (int'(v) == NREQ - 1) ? '0 : v + 1'b1;
  endfunction

  // Round-robin pick: descending scan so the lowest offset from ptr wins.
  always_comb begin
    logic [IW-1:0] idx;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (s_tvalid[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Zero-latency grant mux; grant is zero in IDLE so every output is quiet there.
  assign busy      = (state == XFER);
  assign cur_valid = busy & s_tvalid[grant_id];
  assign cur_last  = busy & s_tlast[grant_id];
  assign m_tvalid  = cur_valid;
  assign m_tlast   = cur_last;
  assign m_tdata   = busy ? s_tdata[grant_id*DW +: DW] : '0;
  assign s_tready  = grant & {NREQ{m_tready}};
  assign hs        = cur_valid & m_tready;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_nxt       = state;
    grant_nxt       = grant;
    grant_id_nxt    = grant_id;
    ptr_nxt         = ptr;
    wd_nxt          = wd_cnt;
    frame_done_nxt  = 1'b0;
    timeout_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        wd_nxt = '0;
        if (pick_vld) begin
          state_nxt         = XFER;
          grant_nxt         = '0;
          grant_nxt[pick]   = 1'b1;
          grant_id_nxt      = pick;
        end
      end
      XFER: begin
        if (hs && cur_last) begin
          state_nxt      = IDLE;
          grant_nxt      = '0;
          ptr_nxt        = wrap_inc(grant_id);
          wd_nxt         = '0;
          frame_done_nxt = 1'b1;
        end else if (wd_cnt == WW'(TOUT)) begin
          // Counter reached TOUT on the previous edge; tlast above takes priority.
          state_nxt       = IDLE;
          grant_nxt       = '0;
          ptr_nxt         = wrap_inc(grant_id);
          wd_nxt          = '0;
          timeout_err_nxt = 1'b1;
        end else if (cur_valid) begin
          wd_nxt = '0;
        end else begin
          wd_nxt = wd_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_id    <= '0;
      ptr         <= '0;
      wd_cnt      <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state       <= state_nxt;
      grant       <= grant_nxt;
      grant_id    <= grant_id_nxt;
      ptr         <= ptr_nxt;
      wd_cnt      <= wd_nxt;
      frame_done  <= frame_done_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_readbuf_stream_arbiter.sv
// Directed self-checking bench for readbuf_stream_arbiter (NREQ=4, DW=8, TOUT=16).
module tb_readbuf_stream_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TOUT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      tv, tl, s_tready, grant;
  logic [31:0]     td;
  logic            m_tvalid, m_tlast, m_tready, busy, frame_done, timeout_err;
  logic [7:0]      m_tdata;
  logic [1:0]      grant_id;
  int              checks = 0;
  int              failures = 0;
  logic            seen_te;

  readbuf_stream_arbiter #(.NREQ(NREQ), .DW(DW), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(tv), .s_tlast(tl), .s_tdata(td), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tdata(m_tdata), .m_tready(m_tready),
    .grant(grant), .grant_id(grant_id), .busy(busy),
    .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; inputs change there, outputs are read 1ns later.
  task automatic nedge();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_data(input int ch, input logic [7:0] v);
    td[ch*8 +: 8] = v;
  endtask

  initial begin
    rst = 1'b1; tv = '0; tl = '0; td = '0; m_tready = 1'b1;
    nedge(); nedge(); settle();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_pulses", 32'({frame_done, timeout_err}), 32'h0);
    check("rst_mvalid", 32'(m_tvalid), 32'h0);
    nedge(); rst = 1'b0;

    // Channel 1, three beats.
    nedge(); tv = 4'b0010; set_data(1, 8'hA1); settle();
    check("t1_idle_mvalid", 32'(m_tvalid), 32'h0);
    check("t1_idle_sready", 32'(s_tready), 32'h0);
    check("t1_idle_mdata", 32'(m_tdata), 32'h0);
    nedge(); settle();
    check("t1_grant", 32'(grant), 32'h2);
    check("t1_grant_id", 32'(grant_id), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_sready", 32'(s_tready), 32'h2);
    check("t1_beat1", 32'(m_tdata), 32'hA1);
    nedge(); set_data(1, 8'hA2); settle();
    check("t1_beat2", 32'(m_tdata), 32'hA2);
    check("t1_last0", 32'(m_tlast), 32'h0);
    nedge(); set_data(1, 8'hA3); tl = 4'b0010; settle();
    check("t1_beat3", 32'(m_tdata), 32'hA3);
    check("t1_last1", 32'(m_tlast), 32'h1);
    check("t1_no_fd_yet", 32'(frame_done), 32'h0);
    nedge(); tv = '0; tl = '0; settle();
    check("t1_fd", 32'(frame_done), 32'h1);
    check("t1_grant0", 32'(grant), 32'h0);
    check("t1_gid_hold", 32'(grant_id), 32'h1);
    check("t1_te", 32'(timeout_err), 32'h0);
    nedge(); settle();
    check("t1_fd_pulse", 32'(frame_done), 32'h0);

    // Reset so the pointer starts at channel 0, then channels 0 and 2 compete.
    nedge(); rst = 1'b1;
    nedge(); rst = 1'b0;
    nedge(); tv = 4'b0101; set_data(0, 8'h10); set_data(2, 8'h20); settle();
    nedge(); settle();
    check("t2_g0", 32'(grant), 32'h1);
    check("t2_g0_d0", 32'(m_tdata), 32'h10);
    check("t2_g0_sready", 32'(s_tready), 32'h1);
    nedge(); set_data(0, 8'h11); tl = 4'b0001; settle();
    check("t2_g0_d1", 32'(m_tdata), 32'h11);
    check("t2_g0_last", 32'(m_tlast), 32'h1);
    nedge(); set_data(0, 8'h12); settle();  // ch0 re-requests with a one-beat frame
    check("t2_dead1_grant", 32'(grant), 32'h0);
    check("t2_dead1_fd", 32'(frame_done), 32'h1);
    check("t2_dead1_mvalid", 32'(m_tvalid), 32'h0);
    nedge(); settle();
    check("t2_g2", 32'(grant), 32'h4);
    check("t2_g2_id", 32'(grant_id), 32'h2);
    check("t2_g2_d0", 32'(m_tdata), 32'h20);
    check("t2_g2_sready", 32'(s_tready), 32'h4);
    check("t2_g2_last0", 32'(m_tlast), 32'h0);
    nedge(); set_data(2, 8'h21); tl = 4'b0101; settle();
    check("t2_g2_d1", 32'(m_tdata), 32'h21);
    nedge(); set_data(2, 8'h22); settle();
    check("t2_dead2_grant", 32'(grant), 32'h0);
    nedge(); settle();
    check("t2_g0b", 32'(grant), 32'h1);
    check("t2_g0b_d", 32'(m_tdata), 32'h12);
    nedge(); tv = 4'b0100; settle();
    check("t2_dead3_grant", 32'(grant), 32'h0);
    nedge(); settle();
    check("t2_g2b", 32'(grant), 32'h4);
    check("t2_g2b_d", 32'(m_tdata), 32'h22);
    nedge(); tv = '0; tl = '0; settle();
    check("t2_end_fd", 32'(frame_done), 32'h1);

    // Channel 3 with long downstream backpressure: watchdog must stay quiet.
    m_tready = 1'b0;
    nedge(); tv = 4'b1000; set_data(3, 8'h30); settle();
    nedge(); settle();
    check("t3_grant", 32'(grant), 32'h8);
    check("t3_sready_bp", 32'(s_tready), 32'h0);
    seen_te = 1'b0;
    for (int i = 0; i < 500; i++) begin
      nedge(); settle();
      seen_te = seen_te | timeout_err;
    end
    check("t3_no_timeout", 32'(seen_te), 32'h0);
    check("t3_grant_held", 32'(grant), 32'h8);
    nedge(); tl = 4'b1000; m_tready = 1'b1; settle();
    check("t3_sready", 32'(s_tready), 32'h8);
    check("t3_last", 32'(m_tlast), 32'h1);
    nedge(); tv = '0; tl = '0; settle();
    check("t3_fd", 32'(frame_done), 32'h1);
    check("t3_te", 32'(timeout_err), 32'h0);

    // Watchdog: ch0 sends one beat then starves; ch1 waits with a one-beat frame.
    nedge(); tv = 4'b0011; set_data(0, 8'h40); set_data(1, 8'h50); tl = 4'b0010; settle();
    nedge(); settle();
    check("t4_grant0", 32'(grant), 32'h1);
    check("t4_beat", 32'(m_tdata), 32'h40);
    seen_te = 1'b0;
    for (int i = 0; i < TOUT; i++) begin
      nedge(); tv = 4'b0010; settle();
      seen_te = seen_te | timeout_err;
    end
    check("t4_no_early_te", 32'(seen_te), 32'h0);
    nedge(); settle();
    check("t4_hold_at_tout", 32'(grant), 32'h1);
    check("t4_te_not_yet", 32'(timeout_err), 32'h0);
    nedge(); settle();
    check("t4_te", 32'(timeout_err), 32'h1);
    check("t4_fd0", 32'(frame_done), 32'h0);
    check("t4_released", 32'(grant), 32'h0);
    check("t4_busy0", 32'(busy), 32'h0);
    nedge(); settle();
    check("t4_next_ch1", 32'(grant), 32'h2);
    check("t4_ch1_data", 32'(m_tdata), 32'h50);
    check("t4_te_pulse", 32'(timeout_err), 32'h0);
    nedge(); tv = '0; tl = '0; settle();
    check("t4_ch1_fd", 32'(frame_done), 32'h1);

    // Expiry cycle coincides with the tlast handshake on channel 2.
    nedge(); tv = 4'b0100; set_data(2, 8'h60); settle();
    nedge(); settle();
    check("t5_grant", 32'(grant), 32'h4);
    for (int i = 0; i < TOUT; i++) begin
      nedge(); tv = '0; settle();
    end
    nedge(); tv = 4'b0100; tl = 4'b0100; set_data(2, 8'h61); settle();
    check("t5_last_beat", 32'(m_tdata), 32'h61);
    nedge(); tv = '0; tl = '0; settle();
    check("t5_fd", 32'(frame_done), 32'h1);
    check("t5_te", 32'(timeout_err), 32'h0);
    check("t5_grant0", 32'(grant), 32'h0);

    // Asynchronous reset mid-frame on channel 3, then pointer restarts at 0.
    nedge(); tv = 4'b1000; set_data(3, 8'h70); settle();
    nedge(); settle();
    check("t6_busy", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_grant", 32'(grant), 32'h0);
    check("t6_rst_mvalid", 32'(m_tvalid), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_pulses", 32'({frame_done, timeout_err}), 32'h0);
    nedge(); rst = 1'b0; tv = 4'b1001; tl = 4'b0001; set_data(0, 8'h80); settle();
    nedge(); settle();
    check("t6_ptr_restart", 32'(grant), 32'h1);
    check("t6_gid", 32'(grant_id), 32'h0);
    check("t6_data", 32'(m_tdata), 32'h80);
    nedge(); tv = '0; tl = '0; settle();
    check("t6_fd", 32'(frame_done), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish observed=running expected=done");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/readbuf_stream_arbiter.md
Name: readbuf_stream_arbiter

Overview:
Frame-level round-robin arbiter that shares one downstream AXI-Stream byte port among NREQ readbuf FSM channels, each with its own three-cycle delay stage. The grant is held from the first beat until the tlast handshake, so frames never interleave. The data/valid/ready path is purely combinational through the grant mux, which keeps each channel's delayed tvalid/tlast aligned with its BRAM read data. A source-starvation watchdog releases a stalled grant.

Parameters:
NREQ, 4, number of requesting readbuf channels (2..8)
DW, 8, tdata width in bits per channel
TOUT, 255, consecutive source-idle cycles inside a frame before forced release (1..65535)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
s_tvalid  input  NREQ  per-channel tvalid (bit i = channel i)
s_tlast  input  NREQ  per-channel tlast
s_tdata  input  NREQ*DW  per-channel tdata, channel i at [i*DW +: DW]
s_tready  output  NREQ  per-channel tready
m_tvalid  output  1  downstream tvalid
m_tlast  output  1  downstream tlast
m_tdata  output  DW  downstream tdata
m_tready  input  1  downstream tready
grant  output  NREQ  registered one-hot grant; zero when idle
grant_id  output  $clog2(NREQ)  index of the current or most recent grant
busy  output  1  high while in XFER
frame_done  output  1  one-cycle pulse on the tlast handshake
timeout_err  output  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (async assert, sync release): state IDLE, grant=0, grant_id=0, rr pointer=0, watchdog=0, busy=0, frame_done=0, timeout_err=0.
- While grant=0: m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=0.
- States: IDLE, XFER.
- IDLE, with any s_tvalid set:
  - Select the first set bit scanning pointer, pointer+1, ... with wrap modulo NREQ.
  - Register grant/grant_id at the clock edge and go to XFER.
  - With no s_tvalid set, stay in IDLE.
- XFER, granted channel g:
  - m_tvalid=s_tvalid[g], m_tlast=s_tlast[g], m_tdata=s_tdata[g].
  - s_tready[g]=m_tready; all other s_tready bits are 0.
  - These paths are combinational and add zero latency.
- Handshake = m_tvalid & m_tready.
- Handshake with m_tlast=1:
  - Next edge: state IDLE, grant=0, pointer=(g+1) mod NREQ, frame_done pulses for one cycle.
  - Result: exactly one dead cycle between consecutive frames.
- Arbitration latency: a request first seen in IDLE at edge k is granted at edge k; its first beat can transfer in the cycle after edge k.
- Watchdog:
  - Counts XFER cycles with s_tvalid[g]=0.
  - Clears on any cycle with s_tvalid[g]=1.
  - Downstream backpressure (m_tready=0 while s_tvalid[g]=1) never counts.
- Watchdog reaching TOUT: next edge forces IDLE, grant=0, pointer=(g+1) mod NREQ, timeout_err pulses for one cycle, frame_done stays 0.
- Simultaneous tlast handshake and watchdog expiry: the tlast handshake wins; frame_done=1, timeout_err=0.
- Requests on non-granted channels during XFER are ignored; those channels see s_tready=0 and must hold.
- Reset mid-frame: immediate release with no pulses; the partial frame is dropped downstream.
- grant_id holds its last value in IDLE. busy equals (state==XFER).

Test Plan:
- Channel 1 only: 3 beats 0xA1,0xA2,0xA3(tlast), m_tready=1 -> grant=4'b0010, m_tdata sequence A1,A2,A3, frame_done one cycle after A3, grant=0.
- Channels 0 and 2 request together, each with a 2-beat frame, then re-request -> grant order 0,2,0,2; one idle cycle between frames; no interleaved beats.
- Channel 3 granted, m_tready=0 for 500 cycles with s_tvalid[3]=1 -> no timeout_err; frame completes normally after m_tready rises.
- TOUT=16, channel 0 sends one beat then drops s_tvalid for 16 cycles -> timeout_err pulse, grant=0, next grant goes to channel 1 if it is requesting.
- Expiry edge coincides with the tlast handshake -> frame_done=1, timeout_err=0.
- rst asserted asynchronously mid-frame (between edges) -> grant, m_tvalid, busy go to 0 immediately; after release the pointer restarts at channel 0.
